// File: rtl/axi_kiwi_cfg_slave.sv
// AXI4-Lite control/status register file for the SDR receiver.
// Optional macro KIWI_CFG_WSTB_EN adds the cfg_wstb per-word write strobe port.
module axi_kiwi_cfg_slave #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int CFG_WORDS      = 8,
    parameter int STS_WORDS      = 8,
    parameter int STS_SEL_BIT    = 12
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [31:0]               s_axi_wdata,
    input  logic [3:0]                s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [31:0]               s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    input  logic [32*STS_WORDS-1:0]   sts_data,
    output logic [32*CFG_WORDS-1:0]   cfg_data
`ifdef KIWI_CFG_WSTB_EN
    ,
    output logic [CFG_WORDS-1:0]      cfg_wstb
`endif
);

    localparam int IDXW = STS_SEL_BIT - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [31:0] cfg_q [CFG_WORDS];

    // Ready lines stay low for the first cycle out of reset.
    logic alive;

    logic                      aw_done, w_done;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]               w_data_q;
    logic [3:0]                w_strb_q;

    logic                      aw_hs, w_hs, wr_commit;
    logic [AXI_ADDR_WIDTH-1:0] wa;
    logic [31:0]               wd;
    logic [3:0]                ws;
    logic [IDXW-1:0]           wr_idx;
    logic                      wr_cfg_ok;

    logic                      ar_hs;
    logic [IDXW-1:0]           rd_idx;
    logic [31:0]               rd_word;
    logic                      rd_ok;

    logic unused_addr_bits;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // A channel captured earlier wins over the live bus for the commit.
    assign wa = aw_done ? aw_addr_q : s_axi_awaddr;
    assign wd = w_done  ? w_data_q  : s_axi_wdata;
    assign ws = w_done  ? w_strb_q  : s_axi_wstrb;

    assign wr_commit = (w_state == W_IDLE)
                     & (aw_done | aw_hs)
                     & (w_done | w_hs);

    assign wr_idx    = wa[STS_SEL_BIT-1:2];
    assign wr_cfg_ok = !wa[STS_SEL_BIT] && (int'(wr_idx) < CFG_WORDS);

    assign rd_idx = s_axi_araddr[STS_SEL_BIT-1:2];

    assign unused_addr_bits = ^{wa[1:0], wa[AXI_ADDR_WIDTH-1:STS_SEL_BIT+1],
                                s_axi_araddr[1:0],
                                s_axi_araddr[AXI_ADDR_WIDTH-1:STS_SEL_BIT+1]};

    // Flat config bus packing, word k at bits [32k+31:32k].
    for (genvar g = 0; g < CFG_WORDS; g++) begin : g_cfg_out
        assign cfg_data[32*g +: 32] = cfg_q[g];
    end

    // Post-reset enable for the ready lines.
    always_ff @(posedge aclk) begin
        if (!aresetn) alive <= 1'b0;
        else          alive <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write FSM next state.
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: if (wr_commit)    w_next = W_RESP;
            W_RESP: if (s_axi_bready) w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs: each channel accepts once per transaction.
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = (w_state == W_RESP);
        if (alive && w_state == W_IDLE) begin
            s_axi_awready = !aw_done;
            s_axi_wready  = !w_done;
        end
    end

    // Hold whichever of AW/W arrives first until its partner shows up.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (wr_commit) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_done   <= 1'b1;
                aw_addr_q <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_done   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
        end
    end

    // Byte-masked update of the addressed config word.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int k = 0; k < CFG_WORDS; k++) cfg_q[k] <= '0;
        end else if (wr_commit && wr_cfg_ok) begin
            for (int k = 0; k < CFG_WORDS; k++) begin
                if (wr_idx == IDXW'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ws[b]) cfg_q[k][8*b +: 8] <= wd[8*b +: 8];
                    end
                end
            end
        end
    end

    // Write response code, fixed at commit.
    always_ff @(posedge aclk) begin
        if (!aresetn)       s_axi_bresp <= RESP_OKAY;
        else if (wr_commit) s_axi_bresp <= wr_cfg_ok ? RESP_OKAY : RESP_SLVERR;
    end

`ifdef KIWI_CFG_WSTB_EN
    // One-cycle strobe aligned with the config word update.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cfg_wstb <= '0;
        end else begin
            for (int k = 0; k < CFG_WORDS; k++) begin
                cfg_wstb[k] <= wr_commit && wr_cfg_ok && (wr_idx == IDXW'(k));
            end
        end
    end
`endif

    // Read FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (ar_hs)        r_next = R_RESP;
            R_RESP: if (s_axi_rready) r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        s_axi_arready = alive && (r_state == R_IDLE);
        s_axi_rvalid  = (r_state == R_RESP);
    end

    // Select the addressed config or status word.
    always_comb begin
        rd_word = '0;
        rd_ok   = 1'b0;
        if (!s_axi_araddr[STS_SEL_BIT]) begin
            for (int k = 0; k < CFG_WORDS; k++) begin
                if (rd_idx == IDXW'(k)) begin
                    rd_word = cfg_q[k];
                    rd_ok   = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < STS_WORDS; k++) begin
                if (rd_idx == IDXW'(k)) begin
                    rd_word = sts_data[32*k +: 32];
                    rd_ok   = 1'b1;
                end
            end
        end
    end

    // Snapshot read data at the address handshake.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axi_rdata <= rd_word;
            s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule
